// File: rtl/lbg_vq_search_if.sv
// Sample-in / result-out handshake bundle for the nearest-codeword search.
interface lbg_vq_search_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 13
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_sample;
  logic                         out_valid;
  logic                         out_ready;
  logic [ADDR_WIDTH-1:0]        out_index;
  logic signed [DATA_WIDTH-1:0] out_codeword;
  logic [DATA_WIDTH:0]          out_dist;

  modport master (
    output in_valid, in_sample, out_ready,
    input  in_ready, out_valid, out_index, out_codeword, out_dist
  );

  modport slave (
    input  in_valid, in_sample, out_ready,
    output in_ready, out_valid, out_index, out_codeword, out_dist
  );
endinterface

// File: rtl/lbg_vq_search.sv
// Exhaustive nearest-codeword search: scans a codebook ROM once per sample and
// returns the index, value and absolute distance of the closest entry.
module lbg_vq_search #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 13,
  parameter int unsigned ROM_OUT_REG = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  lbg_vq_search_if.slave               bus,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic signed [DATA_WIDTH-1:0] rom_data,
  output logic                         busy
);

  localparam int unsigned DW1 = DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e                       state_q;
  logic signed [DATA_WIDTH-1:0] sample_q;
  logic                         issuing_q;
  logic [ADDR_WIDTH-1:0]        rom_addr_q;

  logic                         st_vld_q;
  logic [ADDR_WIDTH-1:0]        st_idx_q;
  logic signed [DATA_WIDTH-1:0] st_cw_q;
  logic [DW1-1:0]               st_dist_q;

  logic [ADDR_WIDTH-1:0]        best_idx_q;
  logic signed [DATA_WIDTH-1:0] best_cw_q;
  logic [DW1-1:0]               best_dist_q;

  logic                         in_ready_q;
  logic                         out_valid_q;
  logic                         busy_q;
  logic [ADDR_WIDTH-1:0]        out_index_q;
  logic signed [DATA_WIDTH-1:0] out_cw_q;
  logic [DW1-1:0]               out_dist_q;

  logic                         pair_vld_c;
  logic [ADDR_WIDTH-1:0]        pair_addr_c;
  logic signed [DW1-1:0]        diff_c;
  logic [DW1-1:0]               abs_c;
  logic                         take_c;
  logic [ADDR_WIDTH-1:0]        mrg_idx_c;
  logic signed [DATA_WIDTH-1:0] mrg_cw_c;
  logic [DW1-1:0]               mrg_dist_c;
  logic                         final_c;

  // Address/valid delay line aligning each ROM word with the address that fetched it.
  generate
    if (ROM_OUT_REG == 0) begin : g_comb_rom
      assign pair_vld_c  = issuing_q;
      assign pair_addr_c = rom_addr_q;
    end else begin : g_reg_rom
      logic                  dly_vld_q;
      logic [ADDR_WIDTH-1:0] dly_addr_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_vld_q  <= 1'b0;
          dly_addr_q <= '0;
        end else begin
          dly_vld_q  <= issuing_q;
          dly_addr_q <= rom_addr_q;
        end
      end
      assign pair_vld_c  = dly_vld_q;
      assign pair_addr_c = dly_addr_q;
    end
  endgenerate

  always_comb begin
    diff_c     = DW1'(sample_q) - DW1'(rom_data);
    abs_c      = diff_c[DW1-1] ? DW1'(-diff_c) : DW1'(diff_c);
    take_c     = st_dist_q < best_dist_q;
    mrg_idx_c  = take_c ? st_idx_q : best_idx_q;
    mrg_cw_c   = take_c ? st_cw_q : best_cw_q;
    mrg_dist_c = take_c ? st_dist_q : best_dist_q;
    final_c    = st_vld_q && (st_idx_q == LAST);
  end

  // Control FSM plus the registered compare pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sample_q    <= '0;
      issuing_q   <= 1'b0;
      rom_addr_q  <= '0;
      st_vld_q    <= 1'b0;
      st_idx_q    <= '0;
      st_cw_q     <= '0;
      st_dist_q   <= '0;
      best_idx_q  <= '0;
      best_cw_q   <= '0;
      best_dist_q <= '1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_index_q <= '0;
      out_cw_q    <= '0;
      out_dist_q  <= '0;
    end else begin
      st_vld_q  <= pair_vld_c;
      st_idx_q  <= pair_addr_c;
      st_cw_q   <= rom_data;
      st_dist_q <= abs_c;
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sample_q    <= bus.in_sample;
            rom_addr_q  <= '0;
            issuing_q   <= 1'b1;
            best_dist_q <= '1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SCAN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SCAN: begin
          if (issuing_q) begin
            if (rom_addr_q == LAST) issuing_q <= 1'b0;
            else                    rom_addr_q <= rom_addr_q + ADDR_WIDTH'(1);
          end
          if (st_vld_q) begin
            best_idx_q  <= mrg_idx_c;
            best_cw_q   <= mrg_cw_c;
            best_dist_q <= mrg_dist_c;
          end
          // Last compare result goes straight to the outputs on the DONE edge.
          if (final_c) begin
            out_index_q <= mrg_idx_c;
            out_cw_q    <= mrg_cw_c;
            out_dist_q  <= mrg_dist_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_index    = out_index_q;
  assign bus.out_codeword = out_cw_q;
  assign bus.out_dist     = out_dist_q;
  assign rom_addr         = rom_addr_q;
  assign busy             = busy_q;

endmodule

// File: doc/lbg_vq_search.md
LBG_VQ_SEARCH -- requirements
Module: lbg_vq_search

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, codebook address width (entries = 2**ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 13, codeword and sample width, two's complement.
REQ-003 SHALL have parameter ROM_OUT_REG, default 0, codebook ROM read latency in cycles (0 or 1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, sample offered.
REQ-007 SHALL have port in_ready, output, 1, block can accept a sample.
REQ-008 SHALL have port in_sample, input, DATA_WIDTH, signed sample to quantise.
REQ-009 SHALL have port rom_addr, output, ADDR_WIDTH, codebook ROM address.
REQ-010 SHALL have port rom_data, input, DATA_WIDTH, signed codeword returned by the ROM.
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port out_index, output, ADDR_WIDTH, index of nearest codeword.
REQ-014 SHALL have port out_codeword, output, DATA_WIDTH, value of nearest codeword.
REQ-015 SHALL have port out_dist, output, DATA_WIDTH+1, unsigned absolute distance to nearest codeword.
REQ-016 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-018 SHALL assert in_ready only in IDLE; a handshake is in_valid && in_ready on a clock edge.
REQ-019 On a handshake, SHALL latch in_sample, set rom_addr to 0, clear the best-distance register to all ones, and enter SCAN.
REQ-020 In SCAN, SHALL increment rom_addr by 1 per cycle from 0 to 2**ADDR_WIDTH-1, then hold it.
REQ-021 SHALL pair each rom_data with the address issued ROM_OUT_REG cycles earlier, using an internal address/valid delay line.
REQ-022 SHALL compute distance as |sample - codeword| with DATA_WIDTH+1-bit signed subtraction and no overflow or saturation.
REQ-023 SHALL update best index, codeword and distance only when the new distance is strictly less than the stored best, so the lowest index wins ties.
REQ-024 SHALL enter DONE once all 2**ADDR_WIDTH comparisons have completed.
REQ-025 SHALL raise out_valid on the edge 2**ADDR_WIDTH+1+ROM_OUT_REG cycles after the handshake edge (17 cycles at default parameters).
REQ-026 In DONE, SHALL hold out_valid, out_index, out_codeword and out_dist stable until out_valid && out_ready.
REQ-027 On out_valid && out_ready, SHALL return to IDLE and deassert out_valid on that edge; in_ready rises on the same edge.
REQ-028 SHALL ignore in_valid and in_sample while not in IDLE; a new sample is never accepted in the same cycle a result is consumed.
REQ-029 SHALL leave result outputs unchanged outside DONE, except that they update from the final comparison on entering DONE.

Reset
REQ-030 When rst is high on a clock edge, SHALL enter IDLE in any state, including mid-SCAN and DONE, and discard any sample in progress.
REQ-031 While rst is high, SHALL drive out_valid=0, busy=0, in_ready=0, rom_addr=0, out_index=0, out_codeword=0 and out_dist=0.
REQ-032 SHALL assert in_ready on the first cycle after rst deasserts.

Verification
REQ-033 Test setup: ROM model with c[i]=256*i-2048 (i=0..15), default parameters.
REQ-034 Sample 0 -> out_index=8, out_codeword=0, out_dist=0; out_valid rises 17 cycles after the handshake.
REQ-035 Sample -4096 -> index 0, codeword -2048, dist 2048. Sample 4095 -> index 15, codeword 1792, dist 2303.
REQ-036 Tie: sample 128 -> index 8, dist 128, never index 9.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles while in_valid stays high -> outputs held stable, in_ready=0, no second sample accepted; in_ready=1 the edge after out_ready is asserted.
REQ-038 Reset mid-operation: assert rst at cycle 7 of SCAN -> out_valid never pulses, in_ready=1 the cycle after rst falls, next sample 300 -> index 9, dist 44.
REQ-039 ROM_OUT_REG=1 with a registered ROM model: sample 0 -> out_index=8 with out_valid rising 18 cycles after the handshake; back-to-back samples -1000 and 1000 -> indices 4 and 12, dists 24 and 24.
